// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains an upstream sfifo into a 3-entry skid buffer and
// presents the buffered words as a valid/ready stream with a transfer counter.
module fifo_stream_out #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_r_en,
   input  logic             flush,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      xfer_cnt
);

   logic [WIDTH-1:0] buf_mem [3];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [1:0]       occ;
   logic             inflight;
   logic             push;
   logic             pop;
   logic [2:0]       committed;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // A read is only issued when a slot is guaranteed for the word one cycle later.
   assign committed = {1'b0, occ} + {2'b00, inflight};
   assign fifo_r_en = !rst && !flush && !fifo_empty && (committed <= 3'd2);

   assign m_valid = (occ != 2'd0);
   assign m_data  = buf_mem[rd_ptr];
   assign push    = inflight && !flush;
   assign pop     = m_valid && m_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 1'b0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         occ      <= 2'd0;
         xfer_cnt <= 16'd0;
      end else if (flush) begin
         inflight <= 1'b0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         occ      <= 2'd0;
      end else begin
         inflight <= fifo_r_en;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            xfer_cnt <= xfer_cnt + 16'd1;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            buf_mem[i] <= '0;
         end
      end else if (push) begin
         buf_mem[wr_ptr] <= fifo_dout;
      end
   end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Self-checking bench for fifo_stream_out: a queue-based sfifo and a queue
// model of the skid buffer predict every output cycle by cycle.
module tb_fifo_stream_out;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_r_en;
   logic             flush;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic [15:0]      xfer_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int ren_pulses  = 0;

   logic [WIDTH-1:0] sfifo_q [$];
   logic [WIDTH-1:0] model_buf [$];
   logic [WIDTH-1:0] pending_word;
   bit               model_inflight;
   logic [15:0]      model_cnt;
   logic [WIDTH-1:0] saved_head;

   always #5 clk = ~clk;

   fifo_stream_out #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_r_en  (fifo_r_en),
      .flush      (flush),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .xfer_cnt   (xfer_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check predictions, then advance the model at posedge.
   task automatic applyStimulus(input bit rdy, input bit fl, input int n_push);
      bit exp_valid;
      bit exp_ren;
      bit obs_ren;
      int committed;
      @(negedge clk);
      fifo_dout = model_inflight ? pending_word : WIDTH'($urandom);
      for (int i = 0; i < n_push; i++) sfifo_q.push_back(WIDTH'($urandom));
      fifo_empty = (sfifo_q.size() == 0);
      m_ready    = rdy;
      flush      = fl;
      #1;
      committed = model_buf.size() + (model_inflight ? 1 : 0);
      exp_valid = (model_buf.size() != 0);
      exp_ren   = !fl && !fifo_empty && (committed <= 2);
      checkOutput("fifo_r_en", fifo_r_en, exp_ren);
      checkOutput("m_valid", m_valid, exp_valid);
      if (exp_valid) checkOutput("m_data", m_data, model_buf[0]);
      checkOutput("xfer_cnt", xfer_cnt, model_cnt);
      obs_ren = (fifo_r_en === 1'b1);
      if (obs_ren) ren_pulses++;
      @(posedge clk);
      if (fl) begin
         model_buf.delete();
      end else begin
         if (exp_valid && rdy) begin
            void'(model_buf.pop_front());
            model_cnt++;
         end
         if (model_inflight) model_buf.push_back(pending_word);
      end
      model_inflight = 1'b0;
      if (obs_ren && sfifo_q.size() > 0) begin
         pending_word   = sfifo_q.pop_front();
         model_inflight = 1'b1;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      flush      = 1'b0;
      m_ready    = 1'b0;
      sfifo_q.delete();
      model_buf.delete();
      model_inflight = 1'b0;
      model_cnt      = 16'd0;
      fifo_empty     = 1'b1;
      #1;
      checkOutput("rst_r_en", fifo_r_en, 1'b0);
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_m_data", m_data, '0);
      checkOutput("rst_xfer_cnt", xfer_cnt, 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      flush      = 1'b0;
      m_ready    = 1'b0;
      model_inflight = 1'b0;
      pending_word   = '0;
      model_cnt      = 16'd0;

      doReset();

      // Four words streamed with the sink always ready
      sfifo_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      repeat (8) applyStimulus(1'b1, 1'b0, 0);
      #1;
      checkOutput("cnt_after_4", xfer_cnt, 16'd4);

      // Sink stalled: buffer fills to three, fourth word stays upstream
      sfifo_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      ren_pulses = 0;
      repeat (6) applyStimulus(1'b0, 1'b0, 0);
      #1;
      checkOutput("stall_reads", ren_pulses, 3);
      checkOutput("stall_left", sfifo_q.size(), 1);
      checkOutput("stall_head", m_data, 8'hA1);
      repeat (8) applyStimulus(1'b1, 1'b0, 0);
      #1;
      checkOutput("cnt_after_8", xfer_cnt, 16'd8);

      // Twelve words with alternating ready, crossing the pointer wrap
      for (int i = 0; i < 12; i++) sfifo_q.push_back(WIDTH'(8'h10 + i));
      for (int i = 0; i < 32; i++) applyStimulus(i % 2 == 0, 1'b0, 0);
      #1;
      checkOutput("cnt_after_20", xfer_cnt, 16'd20);

      // Flush with two buffered words and one in flight
      for (int i = 0; i < 6; i++) sfifo_q.push_back(WIDTH'(8'h40 + i));
      repeat (3) applyStimulus(1'b0, 1'b0, 0);
      saved_head = sfifo_q[0];
      applyStimulus(1'b1, 1'b1, 0);
      #1;
      checkOutput("flush_valid", m_valid, 1'b0);
      checkOutput("flush_cnt", xfer_cnt, 16'd20);
      repeat (3) applyStimulus(1'b0, 1'b0, 0);
      #1;
      checkOutput("flush_new_head", m_data, saved_head);
      checkOutput("flush_new_valid", m_valid, 1'b1);
      repeat (10) applyStimulus(1'b1, 1'b0, 0);

      // Reset while two words are buffered, then idle with an empty sfifo
      for (int i = 0; i < 6; i++) sfifo_q.push_back(WIDTH'(8'h60 + i));
      repeat (3) applyStimulus(1'b0, 1'b0, 0);
      doReset();
      repeat (4) applyStimulus(1'b1, 1'b0, 0);

      // Counter wrap from a preloaded value
      @(negedge clk);
      force dut.xfer_cnt = 16'hFFFE;
      model_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.xfer_cnt;
      sfifo_q = {8'h01, 8'h02, 8'h03};
      repeat (8) applyStimulus(1'b1, 1'b0, 0);
      #1;
      checkOutput("cnt_wrap", xfer_cnt, 16'h0001);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 19) == 0),
                       (sfifo_q.size() < 8) ? int'($urandom_range(0, 2)) : 0);
      end
      repeat (12) applyStimulus(1'b1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 Parameter: WIDTH, default 8, data width; SHALL match WIDTH of the upstream sfifo.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 fifo_empty  input  1  empty flag from the upstream sfifo.
REQ-005 fifo_dout  input  WIDTH  sfifo read data, valid in the cycle after a cycle with fifo_r_en=1.
REQ-006 fifo_r_en  output  1  read strobe to the sfifo.
REQ-007 flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-008 m_data  output  WIDTH  output stream data (head of skid buffer).
REQ-009 m_valid  output  1  output stream valid.
REQ-010 m_ready  input  1  downstream ready; transfer when m_valid and m_ready are both 1 at posedge.
REQ-011 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-012 Block SHALL drain the sfifo into a 3-entry skid buffer (entries 0..2, wr_ptr/rd_ptr mod 3, occ 0..3), preserving word order.
REQ-013 inflight SHALL be a register equal to the previous cycle's fifo_r_en.
REQ-014 fifo_r_en SHALL be 1 iff !rst && !flush && !fifo_empty && (occ + inflight <= 2); it is never asserted while fifo_empty=1.
REQ-015 On a posedge with inflight=1 and flush=0, fifo_dout SHALL be written to entry wr_ptr and wr_ptr advances (2 wraps to 0).
REQ-016 m_valid SHALL equal (occ != 0); m_data SHALL equal entry rd_ptr.
REQ-017 On a posedge with m_valid && m_ready && !flush, rd_ptr SHALL advance (2 wraps to 0) and xfer_cnt SHALL increment by 1, wrapping 0xFFFF to 0x0000.
REQ-018 occ SHALL update as occ + push - pop; simultaneous push and pop SHALL leave occ unchanged.
REQ-019 occ SHALL never exceed 3 or drop below 0 under any m_ready pattern; overflow is prevented only by REQ-014.
REQ-020 Latency: fifo_empty falling in cycle N with an empty buffer SHALL give fifo_r_en=1 in cycle N and m_valid=1 in cycle N+2.
REQ-021 Throughput: with the sfifo non-empty and m_ready held at 1, the block SHALL transfer one word per cycle in steady state.
REQ-022 m_data/m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 flush=1 at a posedge SHALL set occ, wr_ptr, rd_ptr, and inflight to 0 and discard the word arriving on that edge; it SHALL take precedence over push and pop.
REQ-024 flush SHALL NOT change xfer_cnt, and no transfer SHALL be counted on a flush edge.

Reset
REQ-025 While rst=1: fifo_r_en=0, m_valid=0, m_data=0, xfer_cnt=0, occ=0, inflight=0, wr_ptr=rd_ptr=0, all buffer entries=0.
REQ-026 Reset asserted mid-transfer SHALL abandon any in-flight word; the first post-reset read SHALL start from the current sfifo head.

Verification
REQ-027 Sfifo holds A1,B2,C3,D4; m_ready=1 -> m_data A1,B2,C3,D4 on 4 consecutive cycles starting 2 cycles after first fifo_r_en; xfer_cnt=4.
REQ-028 Same 4 words, m_ready=0 -> exactly 3 fifo_r_en pulses, occ=3, m_data=A1 held, D4 left in sfifo; raise m_ready -> A1..D4 in order, no loss or duplicate.
REQ-029 m_ready toggled 1,0,1,0 over 12 words -> output order preserved across the pointer 2->0 wrap, xfer_cnt=12.
REQ-030 Buffer holds 2 words with 1 in flight, flush=1 for one cycle -> next cycle m_valid=0, occ=0; next word read after flush is the new sfifo head; xfer_cnt unchanged.
REQ-031 rst pulsed while occ=2 -> all outputs at REQ-025 values, including m_valid=0 and xfer_cnt=0, during reset; with the sfifo empty, fifo_r_en stays 0 after release.
REQ-032 xfer_cnt preloaded to 0xFFFE by forcing, 3 transfers -> xfer_cnt=0x0001.
